// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle between the datapath and the multiply/divide unit.
// The master drives requests and the HI/LO writes; the slave returns HI/LO and status.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] busW;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, busA, busB, mthi, mtlo, busW,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, busA, busB, mthi, mtlo, busW,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes, one step per clock.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

  stateT              stateQ, stateD;
  logic [WIDTH-1:0]   hiQ, hiD, loQ, loD;
  // Upper half: multiply accumulator / divide remainder. Lower half: multiplier / quotient.
  logic [2*WIDTH-1:0] accQ, accD;
  logic [WIDTH-1:0]   operandQ, operandD;
  logic               isDivQ, isDivD;
  logic               negResQ, negResD, negRemQ, negRemD;
  logic [CntW-1:0]    cntQ, cntD;
  logic               dbzQ, dbzD;

  logic               isSigned, signA, signB;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     mulSum, divShift, divTrial;
  logic [2*WIDTH-1:0] mulNext, divNext, stepNext, prodNeg;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    isSigned = ~bus.op[0];
    signA    = isSigned & bus.busA[WIDTH-1];
    signB    = isSigned & bus.busB[WIDTH-1];
    magA     = signA ? (~bus.busA + 1'b1) : bus.busA;
    magB     = signB ? (~bus.busB + 1'b1) : bus.busB;

    mulSum   = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, operandQ} : '0);
    mulNext  = {mulSum, accQ[WIDTH-1:1]};

    // Remainder stays below the divisor, so the shifted value always fits in WIDTH+1 bits.
    divShift = {accQ[2*WIDTH-1:WIDTH], accQ[WIDTH-1]};
    divTrial = divShift - {1'b0, operandQ};
    divNext  = divTrial[WIDTH] ? {divShift[WIDTH-1:0], accQ[WIDTH-2:0], 1'b0}
                               : {divTrial[WIDTH-1:0], accQ[WIDTH-2:0], 1'b1};

    stepNext = isDivQ ? divNext : mulNext;
    prodNeg  = '0 - stepNext;
    quo      = stepNext[WIDTH-1:0];
    rem      = stepNext[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    stateD   = stateQ;
    hiD      = hiQ;
    loD      = loQ;
    accD     = accQ;
    operandD = operandQ;
    isDivD   = isDivQ;
    negResD  = negResQ;
    negRemD  = negRemQ;
    cntD     = cntQ;
    dbzD     = dbzQ;

    unique case (stateQ)
      StIdle, StDone: begin
        if (bus.start) begin
          isDivD  = bus.op[1];
          negResD = signA ^ signB;
          negRemD = signA;
          cntD    = '0;
          dbzD    = 1'b0;
          if (bus.op[1] && (bus.busB == '0)) begin
            stateD = StDone;
            dbzD   = 1'b1;
          end else begin
            stateD   = StRun;
            accD     = {{WIDTH{1'b0}}, (bus.op[1] ? magA : magB)};
            operandD = bus.op[1] ? magB : magA;
          end
        end else begin
          stateD = StIdle;
          if (bus.mthi) hiD = bus.busW;
          if (bus.mtlo) loD = bus.busW;
        end
      end
      StRun: begin
        accD = stepNext;
        cntD = cntQ + CntW'(1);
        if (cntQ == CntW'(WIDTH - 1)) begin
          stateD = StDone;
          if (isDivQ) begin
            loD = negResQ ? ('0 - quo) : quo;
            hiD = negRemQ ? ('0 - rem) : rem;
          end else begin
            {hiD, loD} = negResQ ? prodNeg : stepNext;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StIdle;
      hiQ      <= '0;
      loQ      <= '0;
      accQ     <= '0;
      operandQ <= '0;
      isDivQ   <= 1'b0;
      negResQ  <= 1'b0;
      negRemQ  <= 1'b0;
      cntQ     <= '0;
      dbzQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      hiQ      <= hiD;
      loQ      <= loD;
      accQ     <= accD;
      operandQ <= operandD;
      isDivQ   <= isDivD;
      negResQ  <= negResD;
      negRemQ  <= negRemD;
      cntQ     <= cntD;
      dbzQ     <= dbzD;
    end
  end

  assign bus.hi          = hiQ;
  assign bus.lo          = loQ;
  assign bus.busy        = (stateQ == StRun);
  assign bus.done        = (stateQ == StDone);
  assign bus.div_by_zero = dbzQ;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: products, quotients, divide-by-zero,
// HI/LO writes, ignored requests during a run, and reset abort.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   n;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one start, then count edges after the start edge until done rises (bounded).
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cnt);
    bus.start = 1'b1;
    bus.op    = op;
    bus.busA  = a;
    bus.busB  = b;
    step();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.busA  = '0;
    bus.busB  = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.busW  = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'h0);

    // mult -3 * 5, with busy and latency observed
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.busA  = 32'hFFFF_FFFD;
    bus.busB  = 32'd5;
    step();
    bus.start = 1'b0;
    chk("t1_busy", 32'(bus.busy), 32'h1);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("t1_lat", n, 32);
    chk("t1_busy_done", 32'(bus.busy), 32'h0);
    chk("t1_hi", bus.hi, 32'hFFFF_FFFF);
    chk("t1_lo", bus.lo, 32'hFFFF_FFF1);
    step();
    chk("t1_done_pulse", 32'(bus.done), 32'h0);

    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("t2u_hi", bus.hi, 32'hFFFF_FFFE);
    chk("t2u_lo", bus.lo, 32'h0000_0001);
    step();
    runOp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("t2s_hi", bus.hi, 32'h0);
    chk("t2s_lo", bus.lo, 32'h1);
    step();

    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, n);
    chk("t3_div_lat", n, 32);
    chk("t3_div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("t3_div_hi", bus.hi, 32'hFFFF_FFFF);
    step();
    runOp(2'b10, 32'd7, 32'hFFFF_FFFE, n);
    chk("t3_divneg_lo", bus.lo, 32'hFFFF_FFFD);
    chk("t3_divneg_hi", bus.hi, 32'h1);
    step();
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("t3_wrap_lo", bus.lo, 32'h8000_0000);
    chk("t3_wrap_hi", bus.hi, 32'h0);
    step();
    runOp(2'b11, 32'd100, 32'd7, n);
    chk("t3_divu_lo", bus.lo, 32'd14);
    chk("t3_divu_hi", bus.hi, 32'd2);
    // start accepted straight from DONE
    runOp(2'b01, 32'd3, 32'd4, n);
    chk("t3_from_done_lat", n, 32);
    chk("t3_from_done_lo", bus.lo, 32'd12);
    step();

    // HI/LO writes, then divide by zero
    bus.mthi = 1'b1;
    bus.busW = 32'h11;
    step();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b1;
    bus.busW = 32'h22;
    step();
    bus.mtlo = 1'b0;
    chk("t4_mthi", bus.hi, 32'h11);
    chk("t4_mtlo", bus.lo, 32'h22);
    runOp(2'b11, 32'd9, 32'd0, n);
    chk("t4_lat", n, 0);
    chk("t4_dbz", 32'(bus.div_by_zero), 32'h1);
    chk("t4_hi", bus.hi, 32'h11);
    chk("t4_lo", bus.lo, 32'h22);
    step();
    chk("t4_dbz_hold", 32'(bus.div_by_zero), 32'h1);
    runOp(2'b00, 32'd2, 32'd3, n);
    chk("t4_dbz_clr", 32'(bus.div_by_zero), 32'h0);
    chk("t4_mul_lo", bus.lo, 32'd6);
    step();
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.busW = 32'h55;
    step();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("t4_both_hi", bus.hi, 32'h55);
    chk("t4_both_lo", bus.lo, 32'h55);
    bus.mthi = 1'b1;
    bus.busW = 32'h0;
    step();
    bus.mthi = 1'b0;

    // mthi and a second start during RUN are ignored
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.busA  = 32'd6;
    bus.busB  = 32'd7;
    step();
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.busA  = 32'd1;
    bus.busB  = 32'd1;
    bus.mthi  = 1'b1;
    bus.busW  = 32'hAAAA;
    step();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    chk("t5_hold_hi", bus.hi, 32'h0);
    chk("t5_hold_lo", bus.lo, 32'h55);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("t5_lat", n, 31);
    chk("t5_hi", bus.hi, 32'h0);
    chk("t5_lo", bus.lo, 32'd42);
    step();
    chk("t5_no_requeue", 32'(bus.busy), 32'h0);
    bus.mtlo = 1'b1;
    bus.busW = 32'h1234;
    step();
    bus.mtlo = 1'b0;
    chk("t5_mtlo", bus.lo, 32'h1234);
    chk("t5_mtlo_hi", bus.hi, 32'h0);

    // reset on the 10th RUN edge aborts the divide
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.busA  = 32'd100;
    bus.busB  = 32'd7;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_hi", bus.hi, 32'h0);
    chk("t6_lo", bus.lo, 32'h0);
    chk("t6_busy", 32'(bus.busy), 32'h0);
    chk("t6_done", 32'(bus.done), 32'h0);
    // mthi alongside an accepted start loses to the start
    bus.mthi = 1'b1;
    bus.busW = 32'hDEAD;
    runOp(2'b00, 32'd2, 32'd3, n);
    chk("t6_lat", n, 32);
    chk("t6_lo", bus.lo, 32'd6);
    chk("t6_hi_after", bus.hi, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
